usb_bus_arb: RTL
================

// Module: usb_bus_arb
// PURPOSE
//  Two-port round-robin arbiter sharing the USB core's 16-bit CSR/EP-status bus between the CPU (port 0) and a descriptor/DMA engine (port 1).
//  Serialises accesses, holds address/data/we stable for the full variable-latency transaction, and forces the one-cycle bus_cyc gap the core needs between transactions.
//  Bounds every access with a timeout and returns an error ack if bus_ack never arrives.
// PARAMETERS
//  TIMEOUT  64  cycles in XFER without bus_ack before error completion (2..65535)
//  TW       $clog2(TIMEOUT+1)  auto-set, timeout counter width
// PORTS
//  clk       in   1   system clock (same domain as USB core)
//  rst       in   1   reset, asynchronous, active-high
//  rN_cyc    in   1   port N request (N=0,1); held high until rN_ack
//  rN_we     in   1   port N write enable
//  rN_addr   in   12  port N address (bit 11 selects EP status)
//  rN_din    in   16  port N write data
//  rN_dout   out  16  port N read data, valid while rN_ack=1
//  rN_ack    out  1   port N completion strobe, one cycle
//  rN_err    out  1   port N timeout flag, qualifies rN_ack
//  bus_addr  out  12  to core
//  bus_din   out  16  to core
//  bus_we    out  1   to core
//  bus_cyc   out  1   to core
//  bus_dout  in   16  from core
//  bus_ack   in   1   from core
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant=1 (port 0 wins first tie); timer 0.
//  All outputs registered; no combinational path from any input to any output.
//  States IDLE, XFER, GAP.
//  - IDLE: if any rN_cyc, pick grant g.
//    - One requester: grant it.
//    - Both: grant the port != last_grant.
//    - Latch rg_addr/rg_din/rg_we into bus_addr/bus_din/bus_we; bus_cyc<=1; timer<=TIMEOUT-1; -> XFER.
//    - bus_cyc rises the cycle after the request is first seen (1-cycle grant latency).
//  - XFER: bus_addr/bus_din/bus_we/bus_cyc held constant.
//    - On bus_ack: bus_cyc<=0; rg_dout<=bus_dout (reads; 0 for writes); rg_ack<=1; last_grant<=g; -> GAP.
//    - Else if timer==0: bus_cyc<=0; rg_ack<=1; rg_err<=1; rg_dout<=16'h0000; last_grant<=g; -> GAP.
//    - Else timer decrements by 1.
//  - GAP: exactly one cycle.
//    - bus_cyc=0; rg_ack/rg_err high this cycle only, then cleared; -> IDLE.
//    - bus_addr/bus_din/bus_we keep last values; rN_dout holds until next ack.
//  Requester contract: drop rN_cyc on the edge that samples rN_ack. IDLE then re-arbitrates without re-serving the finished request.
//  Abort: if rg_cyc falls during XFER, the core transaction still completes (no mid-access abort). Data is discarded and rg_ack/rg_err are suppressed; last_grant still updates.
//  Ack on a bus_ack in the same cycle as timer==0: the ack wins and rg_err=0.
//  Back-to-back throughput: one access per (core latency + 2) cycles. Both ports continuously requesting strictly alternate.
//  Ungranted port: ack/err stay 0; its request waits with no starvation (max wait = one other transaction).
//  Async reset mid-XFER: bus_cyc drops immediately. The pending access is lost with no ack; the requester must re-issue.
// TESTING
//  - Port0 CSR read addr 0x000, core acks 1 cycle after bus_cyc -> r0_ack 3 cycles after r0_cyc, r0_dout = core data, r0_err=0.
//  - Both ports request simultaneously from reset (r0 write 0x001, r1 read 0x800) -> port0 served first, bus_cyc low for 1 cycle, then port1; next tie grants port0.
//  - EP-status read with 5-cycle ack latency while r1_cyc asserted mid-transfer -> bus_addr stable for all 5 cycles, r1 granted only after GAP.
//  - Core never acks (TIMEOUT=64) -> bus_cyc high for exactly 64 cycles, then r0_ack=r0_err=1 and r0_dout=0; next request served normally.
//  - r1 drops r1_cyc during XFER -> no r1_ack, bus_cyc falls on bus_ack, arbiter returns to IDLE.
//  - Assert rst while bus_cyc=1 -> bus_cyc, all acks/errs 0 same cycle; after release, first tie goes to port0.

Source files
------------

// File: rtl/usb_bus_arb.sv
// Two-port round-robin arbiter for the USB core CSR/EP-status bus.
// It serialises CPU (port 0) and DMA (port 1) accesses, times each one out, and leaves an idle gap between them.
module usb_bus_arb #(
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_cyc_i,
    input  logic        r0_we_i,
    input  logic [11:0] r0_addr_i,
    input  logic [15:0] r0_din_i,
    output logic [15:0] r0_dout_o,
    output logic        r0_ack_o,
    output logic        r0_err_o,
    input  logic        r1_cyc_i,
    input  logic        r1_we_i,
    input  logic [11:0] r1_addr_i,
    input  logic [15:0] r1_din_i,
    output logic [15:0] r1_dout_o,
    output logic        r1_ack_o,
    output logic        r1_err_o,
    output logic [11:0] bus_addr_o,
    output logic [15:0] bus_din_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    input  logic [15:0] bus_dout_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            abort_q, abort_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [11:0]     addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic [15:0]     dout0_q, dout0_d, dout1_q, dout1_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            err0_q, err0_d, err1_q, err1_d;

    logic            pick;
    logic            owner_cyc;
    logic            keep;
    logic [15:0]     rdata;

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        abort_d      = abort_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        dout0_d      = dout0_q;
        dout1_d      = dout1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;

        pick      = (r0_cyc_i && r1_cyc_i) ? ~last_grant_q : r1_cyc_i;
        owner_cyc = grant_q ? r1_cyc_i : r0_cyc_i;
        // A requester that let go at any point during the access gets no completion.
        keep      = ~abort_q & owner_cyc;
        rdata     = (bus_ack_i && !we_q) ? bus_dout_i : 16'h0000;

        unique case (state_q)
            IDLE: begin
                if (r0_cyc_i || r1_cyc_i) begin
                    grant_d = pick;
                    addr_d  = pick ? r1_addr_i : r0_addr_i;
                    din_d   = pick ? r1_din_i  : r0_din_i;
                    we_d    = pick ? r1_we_i   : r0_we_i;
                    cyc_d   = 1'b1;
                    abort_d = 1'b0;
                    timer_d = TW'(TIMEOUT - 1);
                    state_d = XFER;
                end
            end
            XFER: begin
                abort_d = ~keep;
                if (bus_ack_i || timer_q == '0) begin
                    cyc_d        = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = GAP;
                    if (keep) begin
                        if (grant_q) begin
                            ack1_d  = 1'b1;
                            err1_d  = ~bus_ack_i;
                            dout1_d = rdata;
                        end else begin
                            ack0_d  = 1'b1;
                            err0_d  = ~bus_ack_i;
                            dout0_d = rdata;
                        end
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            abort_q      <= 1'b0;
            timer_q      <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            dout0_q      <= '0;
            dout1_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            abort_q      <= abort_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            dout0_q      <= dout0_d;
            dout1_q      <= dout1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign bus_addr_o = addr_q;
    assign bus_din_o  = din_q;
    assign bus_we_o   = we_q;
    assign bus_cyc_o  = cyc_q;
    assign r0_dout_o  = dout0_q;
    assign r0_ack_o   = ack0_q;
    assign r0_err_o   = err0_q;
    assign r1_dout_o  = dout1_q;
    assign r1_ack_o   = ack1_q;
    assign r1_err_o   = err1_q;

endmodule
